audio_note_sequencer: RTL and testbench

AUDIO_NOTE_SEQUENCER -- requirements
Module: audio_note_sequencer

---
 rtl/audio_pkg.sv | 12 +
 rtl/note_index_gen.sv | 57 +++++
 rtl/audio_note_sequencer.sv | 106 ++++++++++
 tb/tb_audio_note_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types for the alarm-tone note sequencer: FSM states and play modes.
package audio_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PUSH} state_e;

  typedef enum logic [MODE_W-1:0] {
    CYCLE    = 2'd0,
    PINGPONG = 2'd1,
    HOLD     = 2'd2
  } mode_e;
endpackage

// File: rtl/note_index_gen.sv
// Source-index stepper: picks the next note ROM on every step pulse.
// mode and sel matter only on the step cycle; dir is 1 while descending.
module note_index_gen
  import audio_pkg::*;
#(
  parameter int NUM_SRC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic [MODE_W-1:0] mode,
  input  logic [3:0]        sel,
  output logic [3:0]        idx,
  output logic              dir
);
  localparam logic [3:0] LAST = 4'(NUM_SRC - 1);

  logic [3:0] idx_nx;
  logic       dir_nx;

  always_comb begin
    idx_nx = idx;
    dir_nx = 1'b0;  // any non-pingpong step leaves the direction at "up"
    case (mode)
      PINGPONG: begin
        dir_nx = dir;
        if (!dir) begin
          if (idx == LAST) begin
            idx_nx = idx - 4'd1;
            dir_nx = 1'b1;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end else begin
          if (idx == 4'd0) begin
            idx_nx = 4'd1;
            dir_nx = 1'b0;
          end else begin
            idx_nx = idx - 4'd1;
          end
        end
      end
      HOLD:    idx_nx = (int'(sel) < NUM_SRC) ? sel : 4'd0;
      default: idx_nx = (idx == LAST) ? 4'd0 : idx + 4'd1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      dir <= 1'b0;
    end else if (step) begin
      idx <= idx_nx;
      dir <= dir_nx;
    end
  end
endmodule

// File: rtl/audio_note_sequencer.sv
// Alarm tone player: streams samples from one of NUM_SRC note ROMs to the codec,
// switching ROMs every DWELL accepted samples.
module audio_note_sequencer
  import audio_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int NUM_SRC = 6,
  parameter int ADDR_W  = 13,
  parameter int DWELL   = 48000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [MODE_W-1:0]         mode,
  input  logic [3:0]                sel,
  input  logic [2:0]                vol,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0]         address,
  input  logic                      read_ready,
  input  logic                      write_ready,
  output logic                      read,
  output logic                      write,
  output logic [DATA_W-1:0]         writedata_left,
  output logic [DATA_W-1:0]         writedata_right,
  output logic [3:0]                cur_src,
  output logic                      note_done
);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_e                          state, state_nx;
  logic [NUM_SRC-1:0][DATA_W-1:0]  src_vec;
  logic [DATA_W-1:0]               src_slice;
  logic [DATA_W-1:0]               sample;
  logic [CNT_W-1:0]                dwell_cnt;
  logic                            note_end;
  logic                            unused_dir;

  assign src_vec = src_data;

  always_comb begin
    src_slice = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (cur_src == 4'(k)) src_slice = src_vec[k];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // write is combinational so both enable loss and async reset kill it at once
  always_comb begin
    state_nx = state;
    write    = 1'b0;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: state_nx = LATCH;
      LATCH: state_nx = PUSH;
      PUSH: begin
        if (write_ready && read_ready) begin
          write    = 1'b1;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!enable) begin
      state_nx = IDLE;
      write    = 1'b0;
    end
  end

  assign read     = write;
  assign note_end = write && (dwell_cnt == DWELL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address   <= '0;
      dwell_cnt <= '0;
      sample    <= '0;
      note_done <= 1'b0;
    end else begin
      note_done <= note_end;
      if (state == LATCH) sample <= src_slice;
      if (write) begin
        address   <= address + ADDR_W'(1);
        dwell_cnt <= note_end ? '0 : dwell_cnt + CNT_W'(1);
      end
    end
  end

  assign writedata_left  = $signed(sample) >>> vol;
  assign writedata_right = writedata_left;

  // direction is internal bookkeeping of the stepper; nothing downstream needs it
  note_index_gen #(.NUM_SRC(NUM_SRC)) u_idx (
    .clk  (clk),
    .reset(reset),
    .step (note_end),
    .mode (mode),
    .sel  (sel),
    .idx  (cur_src),
    .dir  (unused_dir)
  );
endmodule

// File: tb/tb_audio_note_sequencer.sv
// Bench for audio_note_sequencer: behavioural model of the sample stream plus
// directed scenarios for cycling, ping-pong, hold, stalls, wrap and reset.
module tb_audio_note_sequencer;
  localparam int DW  = 24;
  localparam int NS  = 6;
  localparam int AW  = 4;
  localparam int DWL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [3:0]        sel = 4'd0;
  logic [2:0]        vol = 3'd0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [AW-1:0]     address;
  logic              read_ready = 1'b1, write_ready = 1'b1;
  logic              read, write;
  logic [DW-1:0]     wdl, wdr;
  logic [3:0]        cur_src;
  logic              note_done;

  int n_checks = 0, n_fail = 0;

  audio_note_sequencer #(.DATA_W(DW), .NUM_SRC(NS), .ADDR_W(AW), .DWELL(DWL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sel(sel), .vol(vol),
    .src_data(src_data), .address(address), .read_ready(read_ready),
    .write_ready(write_ready), .read(read), .write(write),
    .writedata_left(wdl), .writedata_right(wdr), .cur_src(cur_src), .note_done(note_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(int k, int a);
    if (a == 0) return 24'h800000;
    return DW'((k + 1) * 32'h05A3C7) ^ DW'(a * 32'h13579B);
  endfunction

  // ROM bank with one cycle of read latency
  always @(posedge clk)
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] <= rom_val(k, int'(address));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model state
  int m_addr = 0, m_dwell = 0, m_src = 0, m_pos = 0;
  bit m_inpp = 0, exp_nd = 0;
  int cyc = 0, last_wr = -100;
  int log_src[$], log_cyc[$], nd_cyc[$];
  logic [DW-1:0] log_data[$];

  task automatic advance();
    case (mode)
      2'd1: begin
        if (!m_inpp) m_pos = m_src;
        m_inpp = 1;
        m_pos  = (m_pos + 1) % (2*NS - 2);
        m_src  = (m_pos < NS) ? m_pos : 2*NS - 2 - m_pos;
      end
      2'd2: begin
        m_inpp = 0;
        m_src  = (int'(sel) < NS) ? int'(sel) : 0;
      end
      default: begin
        m_inpp = 0;
        m_src  = (m_src + 1) % NS;
      end
    endcase
  endtask

  initial begin : cmp
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        check("rst_write", write, 0);
        check("rst_addr", address, 0);
        check("rst_src", cur_src, 0);
        check("rst_wd", wdl, 0);
        m_addr = 0; m_dwell = 0; m_src = 0; m_pos = 0; m_inpp = 0; exp_nd = 0;
        last_wr = -100;
      end else begin
        check("note_done", note_done, exp_nd);
        if (note_done) nd_cyc.push_back(cyc);
        exp_nd = 0;
        check("address", address, m_addr);
        check("cur_src", cur_src, m_src);
        if (!(enable && write_ready && read_ready)) begin
          check("write_gated", write, 0);
          check("read_gated", read, 0);
        end
        if (write) begin
          e = $signed(rom_val(m_src, m_addr)) >>> vol;
          check("wd_left", wdl, e);
          check("wd_right", wdr, e);
          check("read_with_write", read, 1);
          check("write_spacing", (cyc - last_wr >= 3), 1);
          log_src.push_back(m_src);
          log_cyc.push_back(cyc);
          log_data.push_back(wdl);
          last_wr = cyc;
          m_addr  = (m_addr + 1) % (1 << AW);
          m_dwell++;
          if (m_dwell == DWL) begin
            m_dwell = 0;
            exp_nd  = 1;
            advance();
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  task automatic clear_logs();
    log_src.delete(); log_cyc.delete(); log_data.delete(); nd_cyc.delete();
  endtask

  task automatic wait_note(string name, int exp_src);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      if (note_done) got = 1;
    end
    check({name, "_seen"}, got, 1);
    check(name, cur_src, exp_src);
  endtask

  int t1_exp[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};
  int pp_exp[19] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4, 3, 4, 5};

  initial begin
    int c, sz0;
    bit seen;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    check("reset_addr", address, 0);
    check("reset_src", cur_src, 0);
    check("reset_write", write, 0);
    check("reset_read", read, 0);
    check("reset_wdl", wdl, 0);
    check("reset_wdr", wdr, 0);
    check("reset_nd", note_done, 0);
    reset = 1'b1;
    tick();

    // cycling, latency, spacing, note_done timing, attenuation of full-scale negative
    vol = 3'd3;
    clear_logs();
    c = cyc;
    enable = 1'b1;
    for (int i = 0; i < 60 && log_cyc.size() < 8; i++) begin @(negedge clk); #1; end
    check("t1_writes", log_cyc.size() >= 8, 1);
    if (log_cyc.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t1_src", log_src[i], t1_exp[i]);
        check("t1_cyc", log_cyc[i], c + 4 + 3*i);
      end
      check("t1_vol_neg", log_data[0], 24'hF00000);
    end
    check("t1_nd_count", nd_cyc.size() >= 3, 1);
    if (nd_cyc.size() >= 3)
      for (int j = 0; j < 3; j++) check("t1_nd_cyc", nd_cyc[j], c + 8 + 6*j);

    // ping-pong, then direction reset after leaving ping-pong
    enable = 1'b0;
    tick();
    do_reset();
    clear_logs();
    mode = 2'd1;
    vol = 3'd5;
    enable = 1'b1;
    for (int k = 0; k < 19; k++) begin
      wait_note("pp_src", pp_exp[k]);
      if (k == 16) mode = 2'd0;
      if (k == 17) mode = 2'd1;
    end

    // hold with out-of-range and in-range sel, then mode 3 as cycle
    mode = 2'd2;
    sel = 4'd9;
    wait_note("hold_oor", 0);
    sel = 4'd4;
    repeat (3) begin @(negedge clk); #1; end
    check("hold_wait", cur_src, 0);
    wait_note("hold_sel", 4);
    mode = 2'd3;
    wait_note("mode3", 5);
    wait_note("mode3_wrap", 0);

    // stall in PUSH at the last address, enable drop, wrap coinciding with note end
    enable = 1'b0;
    tick();
    do_reset();
    clear_logs();
    mode = 2'd0;
    vol = 3'd2;
    enable = 1'b1;
    for (int i = 0; i < 200 && log_cyc.size() < 15; i++) begin @(negedge clk); #1; end
    check("t4_reach15", log_cyc.size(), 15);
    tick();
    write_ready = 1'b0;
    sz0 = log_cyc.size();
    repeat (12) tick();
    check("t4_stall_writes", log_cyc.size(), sz0);
    check("t4_stall_addr", address, 15);
    enable = 1'b0;
    write_ready = 1'b1;
    #1 check("t4_drop_write", write, 0);
    repeat (5) tick();
    check("t4_held_addr", address, 15);
    check("t4_held_src", cur_src, 1);
    enable = 1'b1;
    for (int i = 0; i < 20 && log_cyc.size() < sz0 + 1; i++) begin @(negedge clk); #1; end
    check("t4_resume_write", log_cyc.size(), sz0 + 1);
    tick();
    check("t4_wrap_addr", address, 0);
    check("t4_wrap_nd", note_done, 1);
    check("t4_wrap_src", cur_src, 2);

    // asynchronous reset during a write
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (write) seen = 1;
    end
    check("t5_write_seen", seen, 1);
    reset = 1'b0;
    #1;
    check("t5_write", write, 0);
    check("t5_read", read, 0);
    check("t5_addr", address, 0);
    check("t5_src", cur_src, 0);
    check("t5_wdl", wdl, 0);
    check("t5_wdr", wdr, 0);
    check("t5_nd", note_done, 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
